branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Downstream consumer of the PSW condition bits (bit0 = Z, bit1 = N). Holds the program counter and advances it sequentially. Accepts branch, call and return requests. Stalls each request until any in-flight flag-setting ALU op has written the PSW, then evaluates the condition and redirects the PC. Keeps a small return-address stack for call/return.

Parameters:
PC_W, 16, program counter width (bits)
STACK_DEPTH, 4, return-address stack entries (power of 2, >=2)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pc_en  in  1  advance PC by 1 this cycle (sequential fetch)
br_valid  in  1  branch request valid
br_ready  out  1  block can accept a request (high only in IDLE)
br_kind  in  2  00 jump, 01 call, 10 return, 11 reserved (treated as never taken)
br_cond  in  3  condition code, see Behaviour
br_target  in  PC_W  target address (ignored for return)
psw_in  in  2  PSW output: [0] Z, [1] N
psw_pending  in  1  a flag-setting ALU op is in flight; psw_in not yet final
pc_out  out  PC_W  current PC (registered)
flush  out  1  one-cycle pulse when a branch is taken
taken  out  1  one-cycle pulse on every resolve: 1 = taken (valid with resolved)
resolved  out  1  one-cycle pulse when a request completes
stack_overflow  out  1  sticky; call attempted with a full stack
stack_underflow  out  1  sticky; return attempted with an empty stack

Behaviour:
- Reset (async): pc_out=RESET_PC; state=IDLE; stack pointer=0; flush, taken, resolved, and both sticky flags = 0.
- FSM states: IDLE, WAIT_PSW, RESOLVE.
- IDLE:
  - br_ready=1.
  - On br_valid, capture kind, cond and target. Go to WAIT_PSW if psw_pending=1, else RESOLVE.
  - In the accept cycle, pc_en is ignored and the PC holds.
  - If there is no request, pc_out <= pc_out+1 when pc_en. Wraps modulo 2^PC_W.
- WAIT_PSW:
  - br_ready=0; pc_en ignored.
  - Stay while psw_pending=1. Go to RESOLVE the first cycle it is sampled 0.
- RESOLVE: evaluate the condition on the current psw_in (combinational), act, pulse resolved, return to IDLE.
  - Latency with no pending op: accept at cycle T, resolve at T+1, new pc_out visible at T+2.
- Conditions (br_cond):
  - 0 always
  - 1 Z
  - 2 !Z
  - 3 N
  - 4 !N
  - 5 N|Z
  - 6 !N&!Z
  - 7 never
- Actions when the condition is true:
  - jump: pc_out <= target.
  - call: push pc_out (already the address after the branch) and set pc_out <= target. If the stack is full: set stack_overflow, drop the push, pc_out <= target anyway.
  - return: pop into pc_out. If the stack is empty: set stack_underflow, PC holds, taken=0, no flush.
- Condition false: PC holds, no stack change, taken=0, flush=0.
- flush=1 exactly when taken=1. Both are asserted on the cycle after RESOLVE, together with the new pc_out.
- Stack: a LIFO of STACK_DEPTH entries indexed by a pointer 0..STACK_DEPTH. Sticky flags clear only on reset.
- Reset mid-operation (WAIT_PSW/RESOLVE): the request is discarded and all state returns to reset values.

Decomposition:
- Shared package holds:
  - br_kind encodings (JUMP, CALL, RET)
  - br_cond encodings (ALWAYS..NEVER)
  - PSW bit indices (PSW_Z=0, PSW_N=1)
  - FSM state enum
- One sub-module: ras_stack — a parameterised LIFO with push, pop, full, empty and top outputs.
- Condition evaluation stays inline as a function.

Test Plan:
- Reset, then pc_en held for 5 cycles -> pc_out = 0,1,2,3,4,5. With RESET_PC=16'hFFFE, two increments -> pc_out = 16'hFFFF, then 16'h0000.
- pc_out=10, psw_in=2'b01, request jump cond=1 target=100 with psw_pending=0 -> resolved at T+1; at T+2 pc_out=100 and flush=taken=1 for one cycle. Same request with psw_in=2'b00 -> pc_out stays 10, taken=0.
- Request cond=3 with psw_pending=1 for 3 cycles; psw_in changes from 2'b00 to 2'b10 during the wait -> br_ready=0 throughout, branch taken using the final PSW, pc_en ignored during the wait.
- STACK_DEPTH=4: 5 always-calls from pc 1,2,3,4,5 to target 50 -> stack_overflow=1 after the 5th. Then 5 returns -> pc_out 4,3,2,1 (the 5th push was dropped). The 5th return sets stack_underflow=1, pc holds, taken=0.
- br_cond=7 and br_kind=11 -> resolved=1, taken=0, PC and stack unchanged.
- Assert reset while in WAIT_PSW -> outputs take reset values immediately; br_ready=1 on the first clock after release.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolve unit: request kinds, condition codes, PSW bits, FSM states.
// Latency: none (types and constants only); backpressure: not applicable.
package branch_resolve_unit_pkg;

   typedef enum logic [1:0] {
      KIND_JUMP = 2'b00,
      KIND_CALL = 2'b01,
      KIND_RET  = 2'b10,
      KIND_RSVD = 2'b11
   } br_kind_e;

   typedef enum logic [2:0] {
      COND_ALWAYS = 3'd0,
      COND_Z      = 3'd1,
      COND_NZ     = 3'd2,
      COND_N      = 3'd3,
      COND_NN     = 3'd4,
      COND_LE     = 3'd5,
      COND_GT     = 3'd6,
      COND_NEVER  = 3'd7
   } br_cond_e;

   localparam int PSW_Z = 0;
   localparam int PSW_N = 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_PSW = 2'd1,
      ST_RESOLVE  = 2'd2
   } state_e;

endpackage

// File: rtl/branch_resolve_unit_ras_stack.sv
// Return-address LIFO: pointer 0..DEPTH, pushes when full and pops when empty are dropped.
// Latency: push/pop visible on top next cycle; backpressure: none, caller checks full/empty.
module ras_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             full,
   output logic             empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] ptr;

   assign full  = (ptr == PTR_W'(DEPTH));
   assign empty = (ptr == '0);
   // ptr-1 wraps harmlessly when empty; top is only consumed when not empty
   assign top   = mem[IDX_W'(ptr - PTR_W'(1))];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (push && !full) begin
         ptr <= ptr + PTR_W'(1);
      end else if (pop && !empty) begin
         ptr <= ptr - PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[ptr[IDX_W-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// PC holder that resolves jump/call/return requests against the PSW once pending ALU ops retire.
// Latency: accept T, resolve T+1, new PC/flush/taken/resolved at T+2; backpressure: br_ready low outside IDLE.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int              PC_W        = 16,
   parameter int              STACK_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC    = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pc_en,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [1:0]      br_kind,
   input  logic [2:0]      br_cond,
   input  logic [PC_W-1:0] br_target,
   input  logic [1:0]      psw_in,
   input  logic            psw_pending,
   output logic [PC_W-1:0] pc_out,
   output logic            flush,
   output logic            taken,
   output logic            resolved,
   output logic            stack_overflow,
   output logic            stack_underflow
);

   state_e          state, state_nxt;
   br_kind_e        kind_q;
   br_cond_e        cond_q;
   logic [PC_W-1:0] target_q;
   logic [PC_W-1:0] pc_q, pc_nxt;
   logic            flush_q, taken_q, resolved_q, ovf_q, unf_q;
   logic            resolve, cond_ok, taken_nxt;
   logic            push, pop, ovf_set, unf_set;
   logic            ras_full, ras_empty;
   logic [PC_W-1:0] ras_top;

   function automatic logic cond_true(input br_cond_e c, input logic [1:0] psw);
      logic z, n;
      z = psw[PSW_Z];
      n = psw[PSW_N];
      case (c)
         COND_ALWAYS: return 1'b1;
         COND_Z:      return z;
         COND_NZ:     return !z;
         COND_N:      return n;
         COND_NN:     return !n;
         COND_LE:     return n | z;
         COND_GT:     return !n & !z;
         default:     return 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (br_valid) state_nxt = psw_pending ? ST_WAIT_PSW : ST_RESOLVE;
         ST_WAIT_PSW: if (!psw_pending) state_nxt = ST_RESOLVE;
         ST_RESOLVE:  state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // PSW is read live in RESOLVE: WAIT_PSW guarantees it is final by then
   always_comb begin
      resolve   = (state == ST_RESOLVE);
      cond_ok   = resolve && cond_true(cond_q, psw_in);
      push      = 1'b0;
      pop       = 1'b0;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      taken_nxt = 1'b0;
      pc_nxt    = pc_q;
      if (state == ST_IDLE && !br_valid && pc_en) begin
         pc_nxt = pc_q + PC_W'(1);
      end
      if (cond_ok) begin
         case (kind_q)
            KIND_JUMP: begin
               taken_nxt = 1'b1;
               pc_nxt    = target_q;
            end
            KIND_CALL: begin
               taken_nxt = 1'b1;
               pc_nxt    = target_q;
               push      = !ras_full;
               ovf_set   = ras_full;
            end
            KIND_RET: begin
               if (ras_empty) begin
                  unf_set = 1'b1;
               end else begin
                  taken_nxt = 1'b1;
                  pop       = 1'b1;
                  pc_nxt    = ras_top;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kind_q   <= KIND_JUMP;
         cond_q   <= COND_ALWAYS;
         target_q <= '0;
      end else if (state == ST_IDLE && br_valid) begin
         kind_q   <= br_kind_e'(br_kind);
         cond_q   <= br_cond_e'(br_cond);
         target_q <= br_target;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         flush_q    <= 1'b0;
         taken_q    <= 1'b0;
         resolved_q <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         pc_q       <= pc_nxt;
         flush_q    <= taken_nxt;
         taken_q    <= taken_nxt;
         resolved_q <= resolve;
         ovf_q      <= ovf_q | ovf_set;
         unf_q      <= unf_q | unf_set;
      end
   end

   ras_stack #(
      .WIDTH (PC_W),
      .DEPTH (STACK_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (pc_q),
      .top       (ras_top),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   assign br_ready        = (state == ST_IDLE);
   assign pc_out          = pc_q;
   assign flush           = flush_q;
   assign taken           = taken_q;
   assign resolved        = resolved_q;
   assign stack_overflow  = ovf_q;
   assign stack_underflow = unf_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed sequences, a condition table and randomized transactions vs a queue model.
module tb_branch_resolve_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_en, br_valid, psw_pending;
   logic [1:0]  br_kind, psw_in;
   logic [2:0]  br_cond;
   logic [15:0] br_target;
   logic        br_ready, flush, taken, resolved, stack_overflow, stack_underflow;
   logic [15:0] pc_out;
   logic        b_ready, b_flush, b_taken, b_resolved, b_ovf, b_unf;
   logic [15:0] b_pc;

   int checks = 0;
   int errors = 0;

   logic [15:0] pc_m;
   logic [15:0] stk_m[$];
   logic        ovf_m, unf_m;

   typedef struct {
      logic [1:0] kind;
      logic [2:0] cond;
      logic [1:0] psw;
      logic       exp_taken;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   branch_resolve_unit #(.PC_W(16), .STACK_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset), .pc_en(pc_en), .br_valid(br_valid), .br_ready(br_ready),
      .br_kind(br_kind), .br_cond(br_cond), .br_target(br_target), .psw_in(psw_in),
      .psw_pending(psw_pending), .pc_out(pc_out), .flush(flush), .taken(taken),
      .resolved(resolved), .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
   );

   branch_resolve_unit #(.PC_W(16), .STACK_DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_wrap (
      .clk(clk), .reset(reset), .pc_en(pc_en), .br_valid(1'b0), .br_ready(b_ready),
      .br_kind(br_kind), .br_cond(br_cond), .br_target(br_target), .psw_in(psw_in),
      .psw_pending(psw_pending), .pc_out(b_pc), .flush(b_flush), .taken(b_taken),
      .resolved(b_resolved), .stack_overflow(b_ovf), .stack_underflow(b_unf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic cond_model(input int c, input logic z, input logic n);
      case (c)
         0: return 1'b1;
         1: return z;
         2: return !z;
         3: return n;
         4: return !n;
         5: return n || z;
         6: return !(n || z);
         default: return 1'b0;
      endcase
   endfunction

   // one request: pend = number of cycles psw_pending is sampled high starting at the accept cycle
   task automatic do_req(input logic [1:0] k, input logic [2:0] c, input logic [15:0] tgt,
                         input logic [1:0] psw, input int pend, output logic tk);
      logic        exp_tk;
      logic [15:0] exp_pc;
      exp_tk = 1'b0;
      exp_pc = pc_m;
      if (cond_model(int'(c), psw[0], psw[1])) begin
         case (k)
            2'b00: begin exp_tk = 1'b1; exp_pc = tgt; end
            2'b01: begin
               exp_tk = 1'b1;
               exp_pc = tgt;
               if (stk_m.size() < DEPTH) stk_m.push_back(pc_m);
               else ovf_m = 1'b1;
            end
            2'b10: begin
               if (stk_m.size() > 0) begin exp_tk = 1'b1; exp_pc = stk_m.pop_back(); end
               else unf_m = 1'b1;
            end
            default: ;
         endcase
      end
      check("ready_idle", br_ready, 1);
      br_valid = 1'b1; br_kind = k; br_cond = c; br_target = tgt;
      psw_pending = (pend > 0); pc_en = 1'b1; psw_in = ~psw;
      tick();
      br_valid = 1'b0;
      br_target = 16'($urandom);
      for (int i = 1; i < pend; i++) begin
         check("ready_wait", br_ready, 0);
         check("pc_wait", pc_out, pc_m);
         tick();
      end
      if (pend > 0) begin
         psw_pending = 1'b0;
         tick();
      end
      psw_in = psw;
      check("ready_resolve", br_ready, 0);
      check("resolved_early", resolved, 0);
      check("pc_resolve", pc_out, pc_m);
      tick();
      pc_en = 1'b0;
      pc_m = exp_pc;
      check("resolved", resolved, 1);
      check("taken", taken, exp_tk);
      check("flush", flush, exp_tk);
      check("pc_after", pc_out, pc_m);
      check("overflow", stack_overflow, ovf_m);
      check("underflow", stack_underflow, unf_m);
      check("ready_back", br_ready, 1);
      tk = taken;
   endtask

   task automatic idle_run(input int n);
      for (int i = 0; i < n; i++) begin
         pc_en = 1'($urandom);
         br_valid = 1'b0;
         psw_pending = 1'($urandom);
         tick();
         if (pc_en) pc_m = pc_m + 16'd1;
         check("pc_idle", pc_out, pc_m);
         check("pulse_end", {resolved, taken, flush}, 0);
      end
      pc_en = 1'b0;
      psw_pending = 1'b0;
   endtask

   initial begin
      logic        tk;
      logic [15:0] ret_pc [5];
      logic [15:0] wrap_pc;
      ret_pc[0] = 16'd4; ret_pc[1] = 16'd3; ret_pc[2] = 16'd2; ret_pc[3] = 16'd1; ret_pc[4] = 16'd1;

      reset = 1'b1; pc_en = 1'b0; br_valid = 1'b0; br_kind = 2'b00; br_cond = 3'd0;
      br_target = 16'd0; psw_in = 2'b00; psw_pending = 1'b0;
      pc_m = 16'd0; ovf_m = 1'b0; unf_m = 1'b0;
      #12;
      check("rst_pc", pc_out, 16'h0000);
      check("rst_ready", br_ready, 1);
      check("rst_pulses", {resolved, taken, flush}, 0);
      check("rst_sticky", {stack_overflow, stack_underflow}, 0);
      check("rst_pc_wrap", b_pc, 16'hFFFE);
      reset = 1'b0;

      pc_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         pc_m = pc_m + 16'd1;
         check("pc_seq", pc_out, pc_m);
         wrap_pc = 16'hFFFE + 16'(i + 1);
         if (i < 2) check("pc_wrap", b_pc, wrap_pc);
      end
      pc_en = 1'b0;

      do_req(2'b00, 3'd0, 16'd10, 2'b00, 0, tk);
      do_req(2'b00, 3'd1, 16'd100, 2'b01, 0, tk);
      check("jz_taken_pc", pc_out, 16'd100);
      idle_run(1);
      do_req(2'b00, 3'd0, 16'd10, 2'b00, 0, tk);
      do_req(2'b00, 3'd1, 16'd100, 2'b00, 0, tk);
      check("jz_not_taken_pc", pc_out, 16'd10);
      do_req(2'b00, 3'd3, 16'd200, 2'b10, 3, tk);
      check("wait_taken", tk, 1);
      check("wait_pc", pc_out, 16'd200);

      vecs.push_back('{2'b00, 3'd0, 2'b00, 1'b1});
      vecs.push_back('{2'b00, 3'd1, 2'b01, 1'b1});
      vecs.push_back('{2'b00, 3'd1, 2'b00, 1'b0});
      vecs.push_back('{2'b00, 3'd2, 2'b00, 1'b1});
      vecs.push_back('{2'b00, 3'd2, 2'b01, 1'b0});
      vecs.push_back('{2'b00, 3'd3, 2'b10, 1'b1});
      vecs.push_back('{2'b00, 3'd3, 2'b00, 1'b0});
      vecs.push_back('{2'b00, 3'd4, 2'b00, 1'b1});
      vecs.push_back('{2'b00, 3'd4, 2'b10, 1'b0});
      vecs.push_back('{2'b00, 3'd5, 2'b01, 1'b1});
      vecs.push_back('{2'b00, 3'd5, 2'b10, 1'b1});
      vecs.push_back('{2'b00, 3'd5, 2'b00, 1'b0});
      vecs.push_back('{2'b00, 3'd6, 2'b00, 1'b1});
      vecs.push_back('{2'b00, 3'd6, 2'b01, 1'b0});
      vecs.push_back('{2'b00, 3'd7, 2'b11, 1'b0});
      vecs.push_back('{2'b11, 3'd0, 2'b00, 1'b0});
      foreach (vecs[i]) begin
         do_req(vecs[i].kind, vecs[i].cond, 16'h0300 + 16'(i), vecs[i].psw, i % 3, tk);
         check("tbl_taken", tk, vecs[i].exp_taken);
      end

      for (int i = 1; i <= 5; i++) begin
         do_req(2'b00, 3'd0, 16'(i), 2'b00, 0, tk);
         do_req(2'b01, 3'd0, 16'd50, 2'b00, 0, tk);
      end
      check("ovf_after_5_calls", stack_overflow, 1);
      for (int i = 0; i < 5; i++) begin
         do_req(2'b10, 3'd0, 16'd0, 2'b00, 0, tk);
         check("ret_pc", pc_out, ret_pc[i]);
      end
      check("ret_empty_taken", tk, 0);
      check("unf_after_5_rets", stack_underflow, 1);

      for (int i = 0; i < 150; i++) begin
         idle_run($urandom_range(0, 3));
         do_req(2'($urandom), 3'($urandom), 16'($urandom), 2'($urandom), $urandom_range(0, 3), tk);
      end

      do_req(2'b01, 3'd0, 16'd77, 2'b00, 0, tk);
      br_valid = 1'b1; br_kind = 2'b00; br_cond = 3'd0; br_target = 16'd500; psw_pending = 1'b1;
      tick();
      br_valid = 1'b0;
      tick();
      check("mid_wait_ready", br_ready, 0);
      #2 reset = 1'b1;
      #1;
      pc_m = 16'd0; stk_m.delete(); ovf_m = 1'b0; unf_m = 1'b0;
      check("midrst_pc", pc_out, 16'd0);
      check("midrst_ready", br_ready, 1);
      check("midrst_sticky", {stack_overflow, stack_underflow}, 0);
      check("midrst_pulses", {resolved, taken, flush}, 0);
      @(negedge clk);
      reset = 1'b0;
      psw_pending = 1'b0;
      tick();
      check("post_rst_ready", br_ready, 1);
      check("post_rst_pc", pc_out, 16'd0);
      do_req(2'b10, 3'd0, 16'd0, 2'b00, 0, tk);
      check("post_rst_stack_empty", stack_underflow, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
